// File: rtl/bob_resolve_ctrl.sv
// Retire-side branch resolve sequencer: pops the BOB head, emits one predictor update and, on mispredict, runs flush/redirect/restore then a drain window.
// Optional feature macro: BOB_CTRL_PERF_EN adds branch / mispredict event counters on perf_brcnt_o / perf_mpcnt_o.
module bob_resolve_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ext_flush_i,
    input  logic        rt_vld_i,
    output logic        rt_ready_o,
    input  logic        rt_taken_i,
    input  logic        rt_indir_i,
    input  logic        rt_tgtmiss_i,
    input  logic [63:0] rt_target_i,
    input  logic        bob_valid_i,
    input  logic [63:0] bob_brpc_i,
    input  logic        bob_brdir_i,
    input  logic        bob_chwe_i,
    input  logic        bob_chbrdir_i,
    input  logic [9:0]  bob_bht_i,
    input  logic [11:0] bob_bhr_i,
    input  logic [3:0]  bob_rasptr_i,
    output logic        bob_re_o,
    output logic        upd_vld_o,
    output logic [63:0] upd_pc_o,
    output logic        upd_taken_o,
    output logic [9:0]  upd_bht_o,
    output logic [11:0] upd_bhr_o,
    output logic        upd_chwe_o,
    output logic        upd_chbrdir_o,
    output logic        flush_o,
    output logic        redirect_vld_o,
    output logic [63:0] redirect_pc_o,
    output logic [11:0] restore_bhr_o,
    output logic [3:0]  restore_rasptr_o,
    output logic        busy_o,
    output logic [31:0] perf_brcnt_o,
    output logic [31:0] perf_mpcnt_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHECK   = 2'd1,
        S_RECOVER = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_brpc;
    logic [63:0] r_target;
    logic        r_taken;
    logic        r_brdir;
    logic        r_indir;
    logic        r_tgtmiss;
    logic        r_chwe;
    logic        r_chbrdir;
    logic [9:0]  r_bht;
    logic [11:0] r_bhr;
    logic [3:0]  r_rasptr;

    logic        w_live;
    logic        w_accept;
    logic        w_mp;
    logic        w_upd;
    logic        w_rec;

    // Strobes are killed combinationally by reset or an external flush so no partial pulse escapes.
    assign w_live   = reset_n && !ext_flush_i;
    assign w_mp     = (r_taken != r_brdir) || (r_indir && r_taken && r_tgtmiss);
    assign w_upd    = w_live && (r_state == S_CHECK);
    assign w_rec    = w_live && (r_state == S_RECOVER);

    assign rt_ready_o = w_live && (r_state == S_IDLE) && bob_valid_i;
    assign w_accept   = rt_vld_i && rt_ready_o;
    assign bob_re_o   = w_accept;
    assign busy_o     = (r_state != S_IDLE);

    assign upd_vld_o     = w_upd;
    assign upd_pc_o      = w_upd ? r_brpc : 64'd0;
    assign upd_taken_o   = w_upd && r_taken;
    assign upd_bht_o     = w_upd ? r_bht : 10'd0;
    assign upd_bhr_o     = w_upd ? r_bhr : 12'd0;
    assign upd_chwe_o    = w_upd && r_chwe;
    assign upd_chbrdir_o = w_upd && r_chbrdir;

    assign flush_o          = w_rec;
    assign redirect_vld_o   = w_rec;
    assign redirect_pc_o    = !w_rec ? 64'd0 : (r_taken ? r_target : r_brpc + 64'd4);
    assign restore_bhr_o    = w_rec ? {r_bhr[10:0], r_taken} : 12'd0;
    assign restore_rasptr_o = w_rec ? r_rasptr : 4'd0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_brpc    <= 64'd0;
            r_target  <= 64'd0;
            r_taken   <= 1'b0;
            r_brdir   <= 1'b0;
            r_indir   <= 1'b0;
            r_tgtmiss <= 1'b0;
            r_chwe    <= 1'b0;
            r_chbrdir <= 1'b0;
            r_bht     <= 10'd0;
            r_bhr     <= 12'd0;
            r_rasptr  <= 4'd0;
        end else if (ext_flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_brpc    <= bob_brpc_i;
                        r_target  <= rt_target_i;
                        r_taken   <= rt_taken_i;
                        r_brdir   <= bob_brdir_i;
                        r_indir   <= rt_indir_i;
                        r_tgtmiss <= rt_tgtmiss_i;
                        r_chwe    <= bob_chwe_i;
                        r_chbrdir <= bob_chbrdir_i;
                        r_bht     <= bob_bht_i;
                        r_bhr     <= bob_bhr_i;
                        r_rasptr  <= bob_rasptr_i;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_state <= w_mp ? S_RECOVER : S_IDLE;
                end
                S_RECOVER: begin
                    r_cnt   <= DRAIN_LOAD;
                    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BOB_CTRL_PERF_EN
    logic [31:0] r_brcnt;
    logic [31:0] r_mpcnt;

    // Counts only branches whose update actually left the block; flushes do not clear history.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_brcnt <= 32'd0;
            r_mpcnt <= 32'd0;
        end else if (w_upd) begin
            r_brcnt <= r_brcnt + 32'd1;
            if (w_mp) begin
                r_mpcnt <= r_mpcnt + 32'd1;
            end
        end
    end

    assign perf_brcnt_o = r_brcnt;
    assign perf_mpcnt_o = r_mpcnt;
`else
    assign perf_brcnt_o = 32'd0;
    assign perf_mpcnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_bob_resolve_ctrl.sv
// Testbench for bob_resolve_ctrl: vector table driven through the retire handshake, scoreboard on update/redirect pulses,
// plus hand sequences for reset, underflow, ext flush and mid-sequence reset.
module tb_bob_resolve_ctrl;

    localparam int DRAIN = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ext_flush_i;
    logic        rt_vld_i;
    logic        rt_ready_o;
    logic        rt_taken_i;
    logic        rt_indir_i;
    logic        rt_tgtmiss_i;
    logic [63:0] rt_target_i;
    logic        bob_valid_i;
    logic [63:0] bob_brpc_i;
    logic        bob_brdir_i;
    logic        bob_chwe_i;
    logic        bob_chbrdir_i;
    logic [9:0]  bob_bht_i;
    logic [11:0] bob_bhr_i;
    logic [3:0]  bob_rasptr_i;
    logic        bob_re_o;
    logic        upd_vld_o;
    logic [63:0] upd_pc_o;
    logic        upd_taken_o;
    logic [9:0]  upd_bht_o;
    logic [11:0] upd_bhr_o;
    logic        upd_chwe_o;
    logic        upd_chbrdir_o;
    logic        flush_o;
    logic        redirect_vld_o;
    logic [63:0] redirect_pc_o;
    logic [11:0] restore_bhr_o;
    logic [3:0]  restore_rasptr_o;
    logic        busy_o;
    logic [31:0] perf_brcnt_o;
    logic [31:0] perf_mpcnt_o;

    always #5 clock = ~clock;

    bob_resolve_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clock(clock), .reset_n(reset_n), .ext_flush_i(ext_flush_i),
        .rt_vld_i(rt_vld_i), .rt_ready_o(rt_ready_o), .rt_taken_i(rt_taken_i),
        .rt_indir_i(rt_indir_i), .rt_tgtmiss_i(rt_tgtmiss_i), .rt_target_i(rt_target_i),
        .bob_valid_i(bob_valid_i), .bob_brpc_i(bob_brpc_i), .bob_brdir_i(bob_brdir_i),
        .bob_chwe_i(bob_chwe_i), .bob_chbrdir_i(bob_chbrdir_i), .bob_bht_i(bob_bht_i),
        .bob_bhr_i(bob_bhr_i), .bob_rasptr_i(bob_rasptr_i), .bob_re_o(bob_re_o),
        .upd_vld_o(upd_vld_o), .upd_pc_o(upd_pc_o), .upd_taken_o(upd_taken_o),
        .upd_bht_o(upd_bht_o), .upd_bhr_o(upd_bhr_o), .upd_chwe_o(upd_chwe_o),
        .upd_chbrdir_o(upd_chbrdir_o), .flush_o(flush_o), .redirect_vld_o(redirect_vld_o),
        .redirect_pc_o(redirect_pc_o), .restore_bhr_o(restore_bhr_o),
        .restore_rasptr_o(restore_rasptr_o), .busy_o(busy_o),
        .perf_brcnt_o(perf_brcnt_o), .perf_mpcnt_o(perf_mpcnt_o)
    );

    typedef struct {
        logic        taken, brdir, indir, tgtmiss, chwe, chbrdir;
        logic [63:0] pc, target;
        logic [9:0]  bht;
        logic [11:0] bhr;
        logic [3:0]  ras;
        logic        exp_mp;
        logic [63:0] exp_rpc;
        logic [11:0] exp_rbhr;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic        taken, chwe, chbrdir;
        logic [9:0]  bht;
        logic [11:0] bhr;
    } upd_t;

    typedef struct {
        logic [63:0] pc;
        logic [11:0] bhr;
        logic [3:0]  ras;
    } red_t;

    upd_t upd_q[$];
    red_t red_q[$];
    vec_t vecs[8];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic t, b, i, g, cw, cd, input logic [63:0] pc, tgt,
                                input logic [9:0] bht, input logic [11:0] bhr, input logic [3:0] ras,
                                input logic mp, input logic [63:0] rpc, input logic [11:0] rbhr);
        vec_t v;
        v.taken = t; v.brdir = b; v.indir = i; v.tgtmiss = g; v.chwe = cw; v.chbrdir = cd;
        v.pc = pc; v.target = tgt; v.bht = bht; v.bhr = bhr; v.ras = ras;
        v.exp_mp = mp; v.exp_rpc = rpc; v.exp_rbhr = rbhr;
        return v;
    endfunction

    // Scoreboard monitor: every update / redirect pulse must match the oldest pending expectation.
    upd_t mu;
    red_t mr;
    initial begin
        forever begin
            @(negedge clock);
            if (upd_vld_o) begin
                if (upd_q.size() == 0) begin
                    chk("upd_unexpected", {63'd0, upd_vld_o}, 64'd0);
                end else begin
                    mu = upd_q.pop_front();
                    chk("upd_pc", upd_pc_o, mu.pc);
                    chk("upd_taken", {63'd0, upd_taken_o}, {63'd0, mu.taken});
                    chk("upd_bht", {54'd0, upd_bht_o}, {54'd0, mu.bht});
                    chk("upd_bhr", {52'd0, upd_bhr_o}, {52'd0, mu.bhr});
                    chk("upd_chwe", {63'd0, upd_chwe_o}, {63'd0, mu.chwe});
                    chk("upd_chbrdir", {63'd0, upd_chbrdir_o}, {63'd0, mu.chbrdir});
                end
            end
            if (redirect_vld_o || flush_o) begin
                if (red_q.size() == 0) begin
                    chk("redirect_unexpected", {63'd0, redirect_vld_o | flush_o}, 64'd0);
                end else begin
                    mr = red_q.pop_front();
                    chk("flush_with_redirect", {63'd0, flush_o}, {63'd0, redirect_vld_o});
                    chk("redirect_pc", redirect_pc_o, mr.pc);
                    chk("restore_bhr", {52'd0, restore_bhr_o}, {52'd0, mr.bhr});
                    chk("restore_rasptr", {60'd0, restore_rasptr_o}, {60'd0, mr.ras});
                end
            end
        end
    end

    task automatic drive_fields(input vec_t v);
        rt_taken_i = v.taken; rt_indir_i = v.indir; rt_tgtmiss_i = v.tgtmiss;
        rt_target_i = v.target; bob_brpc_i = v.pc; bob_brdir_i = v.brdir;
        bob_chwe_i = v.chwe; bob_chbrdir_i = v.chbrdir; bob_bht_i = v.bht;
        bob_bhr_i = v.bhr; bob_rasptr_i = v.ras;
    endtask

    // Presents a branch and returns in the handshake cycle (sampled at its negedge).
    task automatic handshake(input vec_t v, input bit push_upd);
        int w;
        upd_t u;
        @(posedge clock); #1;
        drive_fields(v);
        bob_valid_i = 1'b1;
        rt_vld_i = 1'b1;
        w = 0;
        @(negedge clock);
        while (!rt_ready_o && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("ready_timeout", {63'd0, rt_ready_o}, 64'd1);
        chk("bob_re_on_handshake", {63'd0, bob_re_o}, 64'd1);
        if (push_upd) begin
            u.pc = v.pc; u.taken = v.taken; u.chwe = v.chwe; u.chbrdir = v.chbrdir;
            u.bht = v.bht; u.bhr = v.bhr;
            upd_q.push_back(u);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        red_t r;
        handshake(v, 1'b1);
        if (v.exp_mp) begin
            r.pc = v.exp_rpc; r.bhr = v.exp_rbhr; r.ras = v.ras;
            red_q.push_back(r);
        end
        @(posedge clock); #1;
        rt_vld_i = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(negedge clock);
            if (n == 1) chk("upd_one_after", {63'd0, upd_vld_o}, 64'd1);
            if (n == 1) chk("no_pop_in_check", {63'd0, bob_re_o}, 64'd0);
            if (n == 2) chk("flush_two_after", {63'd0, flush_o}, {63'd0, v.exp_mp});
            if (rt_ready_o) lat = n;
        end
        chk("ready_latency", 64'(lat), v.exp_mp ? 64'(3 + DRAIN) : 64'd2);
        $display("vec %0d pc=0x%0h taken=%0b brdir=%0b mp=%0b ready_after=%0d", idx, v.pc, v.taken, v.brdir, v.exp_mp, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        //             t  b  i  g  cw cd pc                      target        bht     bhr      ras   mp rpc                  rbhr
        vecs[0] = mk(1, 1, 0, 0, 1, 1, 64'h1000,               64'h5000,     10'h155, 12'h123, 4'd3,  0, 64'h0,               12'h000);
        vecs[1] = mk(0, 1, 0, 0, 0, 0, 64'h2000,               64'h7000,     10'h2AA, 12'hABC, 4'd5,  1, 64'h2004,            12'h578);
        vecs[2] = mk(1, 1, 1, 1, 1, 0, 64'h3000,               64'h8000,     10'h001, 12'h001, 4'd7,  1, 64'h8000,            12'h003);
        vecs[3] = mk(1, 1, 1, 0, 0, 1, 64'h4000,               64'h8800,     10'h3FF, 12'h0F0, 4'd2,  0, 64'h0,               12'h000);
        vecs[4] = mk(1, 1, 0, 1, 1, 1, 64'h4100,               64'h9900,     10'h000, 12'h000, 4'd1,  0, 64'h0,               12'h000);
        vecs[5] = mk(1, 0, 0, 0, 0, 1, 64'h6000,               64'h9000,     10'h123, 12'hFFF, 4'd15, 1, 64'h9000,            12'hFFF);
        vecs[6] = mk(0, 1, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234,    10'h0AA, 12'h401, 4'd0,  1, 64'h0,               12'h802);
        vecs[7] = mk(0, 0, 1, 1, 0, 0, 64'h5000,               64'hA000,     10'h111, 12'h555, 4'd9,  0, 64'h0,               12'h000);

        reset_n = 1'b0; ext_flush_i = 1'b0;
        rt_vld_i = 1'b1; bob_valid_i = 1'b1;
        drive_fields(vecs[0]);
        repeat (2) @(negedge clock);
        chk("rst_ready", {63'd0, rt_ready_o}, 64'd0);
        chk("rst_bob_re", {63'd0, bob_re_o}, 64'd0);
        chk("rst_upd_vld", {63'd0, upd_vld_o}, 64'd0);
        chk("rst_flush", {63'd0, flush_o}, 64'd0);
        chk("rst_redirect_vld", {63'd0, redirect_vld_o}, 64'd0);
        chk("rst_redirect_pc", redirect_pc_o, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_perf_br", {32'd0, perf_brcnt_o}, 64'd0);
        chk("rst_perf_mp", {32'd0, perf_mpcnt_o}, 64'd0);

        @(posedge clock); #1;
        reset_n = 1'b1;
        bob_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("underflow_ready", {63'd0, rt_ready_o}, 64'd0);
            chk("underflow_busy", {63'd0, busy_o}, 64'd0);
        end
        $display("underflow wait: rt_vld=1 bob_valid=0 for 3 cycles");

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

`ifdef BOB_CTRL_PERF_EN
        chk("perf_brcnt", {32'd0, perf_brcnt_o}, 64'd8);
        chk("perf_mpcnt", {32'd0, perf_mpcnt_o}, 64'd4);
`else
        chk("perf_brcnt_off", {32'd0, perf_brcnt_o}, 64'd0);
        chk("perf_mpcnt_off", {32'd0, perf_mpcnt_o}, 64'd0);
`endif

        // ext_flush_i during CHECK of a mispredict: nothing may leave, back to IDLE next cycle.
        handshake(vecs[1], 1'b0);
        @(posedge clock); #1;
        rt_vld_i = 1'b0; bob_valid_i = 1'b0; ext_flush_i = 1'b1;
        @(negedge clock);
        chk("xflush_upd", {63'd0, upd_vld_o}, 64'd0);
        chk("xflush_flush", {63'd0, flush_o}, 64'd0);
        @(posedge clock); #1;
        ext_flush_i = 1'b0;
        @(negedge clock);
        chk("xflush_idle", {63'd0, busy_o}, 64'd0);
        chk("xflush_no_redirect", {63'd0, redirect_vld_o}, 64'd0);
        @(negedge clock);
        chk("xflush_no_late_flush", {63'd0, flush_o}, 64'd0);
        $display("ext flush in CHECK: sequence aborted");

        // Reset in the CHECK cycle of a mispredict: the update is seen, no recovery follows.
        handshake(vecs[1], 1'b1);
        @(posedge clock); #1;
        rt_vld_i = 1'b0; bob_valid_i = 1'b0;
        @(negedge clock);
        #1 reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_flush", {63'd0, flush_o}, 64'd0);
        chk("midrst_redirect", {63'd0, redirect_vld_o}, 64'd0);
        chk("midrst_busy", {63'd0, busy_o}, 64'd0);
        chk("midrst_perf_br", {32'd0, perf_brcnt_o}, 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("midrst_quiet", {63'd0, flush_o | upd_vld_o | busy_o}, 64'd0);
        $display("reset mid-sequence: recovery suppressed");

        chk("upd_q_drained", 64'(upd_q.size()), 64'd0);
        chk("red_q_drained", 64'(red_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
